// File: rtl/spi_master.sv
// spi_master -- command-framed SPI master.
//
// Each frame sends 11 bits, MSB first: {cmd[1], cmd[1:0], din[7:0]}.
// A read-data frame (cmd=11) then idles RD_WAIT cycles with MOSI low and
// clocks in one byte from MISO, MSB first.
//
// Handshake: start is a request and busy is the inverse of ready. A request
// is taken on a rising edge only when busy=0 at that edge, and cmd/din are
// captured at that edge. While busy=1, start is ignored and never queued.
// busy drops on the same edge that pulses done, and that edge cannot accept
// a new start, so SS_n is always high for at least one cycle between frames.
//
// Parameters
//   RD_WAIT    idle cycles between the last MOSI bit and the first MISO
//              sample of a read-data frame (legal range 1..15)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      frame request
//   cmd[1:0]   00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   din[7:0]   payload (ignored when cmd=11)
//   MISO       serial data from the slave
//   abort      (only with SPI_MASTER_ABORT_EN) ends the current frame early
//   SS_n       active-low slave select
//   MOSI       serial data to the slave (0 whenever SS_n=1)
//   busy       high from acceptance until the frame ends
//   done       one-cycle pulse at frame end (including an aborted frame)
//   dout[7:0]  last byte read; changes only when a read-data frame completes
//   rx_valid   one-cycle pulse when dout is loaded
//   fsm_state  current FSM state, for observation
//
// Optional feature: define SPI_MASTER_ABORT_EN to add the abort input.

module spi_master #(
  parameter int unsigned RD_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       MISO,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
`endif
  output logic       SS_n,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_TX = 2'd1,
    WAIT_RX  = 2'd2,
    SHIFT_RX = 2'd3
  } state_t;

  // Count value at which the wait phase ends (the counter starts at 0).
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [10:0] frame, frame_nxt;
  logic [7:0]  rx_sh, rx_sh_nxt;
  logic        ss_n_nxt, mosi_nxt, busy_nxt, done_nxt, rx_valid_nxt;
  logic [7:0]  dout_nxt;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      frame    <= 11'd0;
      rx_sh    <= 8'd0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      dout     <= 8'h00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      frame    <= frame_nxt;
      rx_sh    <= rx_sh_nxt;
      SS_n     <= ss_n_nxt;
      MOSI     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rx_valid <= rx_valid_nxt;
      dout     <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    frame_nxt    = frame;
    rx_sh_nxt    = rx_sh;
    ss_n_nxt     = SS_n;
    mosi_nxt     = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rx_valid_nxt = 1'b0;
    dout_nxt     = dout;

    case (state)
      IDLE: begin
        if (start && !busy) begin
          frame_nxt = {cmd[1], cmd, din};
          cnt_nxt   = 4'd0;
          ss_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT_TX;
        end
      end

      // cnt 0..10 drives frame[10]..frame[0]; the edge at cnt=11 ends the
      // transmit phase, so the last bit is held for a full cycle.
      SHIFT_TX: begin
        if (cnt == 4'd11) begin
          cnt_nxt = 4'd0;
          if (frame[9:8] == 2'b11) begin
            state_nxt = WAIT_RX;
          end else begin
            ss_n_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          mosi_nxt = frame[4'd10 - cnt];
          cnt_nxt  = cnt + 4'd1;
        end
      end

      // The edge that leaves WAIT_RX already takes the first MISO bit, so
      // the counter enters SHIFT_RX holding the number of bits captured.
      WAIT_RX: begin
        if (cnt == WAIT_LAST) begin
          rx_sh_nxt = {rx_sh[6:0], MISO};
          cnt_nxt   = 4'd1;
          state_nxt = SHIFT_RX;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      SHIFT_RX: begin
        if (cnt == 4'd8) begin
          cnt_nxt      = 4'd0;
          dout_nxt     = rx_sh;
          rx_valid_nxt = 1'b1;
          ss_n_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end else begin
          rx_sh_nxt = {rx_sh[6:0], MISO};
          cnt_nxt   = cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef SPI_MASTER_ABORT_EN
    // Abort overrides whatever the frame would have done on this edge,
    // including a read completion: dout stays and rx_valid stays low.
    if (abort && busy) begin
      state_nxt    = IDLE;
      cnt_nxt      = 4'd0;
      ss_n_nxt     = 1'b1;
      mosi_nxt     = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b1;
      rx_valid_nxt = 1'b0;
      dout_nxt     = dout;
    end
`endif
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed self-checking bench for spi_master (RD_WAIT=3).
// Inputs change on the falling edge; outputs are observed on the falling
// edge, so "k" below is the number of rising edges since acceptance edge E.

module tb_spi_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       miso;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
`endif
  logic       ss_n;
  logic       mosi;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       rx_valid;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  spi_master #(.RD_WAIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd       (cmd),
    .din       (din),
    .MISO      (miso),
`ifdef SPI_MASTER_ABORT_EN
    .abort     (abort),
`endif
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge
  // right after acceptance edge E (k=0).
  task automatic start_frame(input logic [1:0] c, input logic [7:0] d, input bit hold);
    cmd   = c;
    din   = d;
    start = 1'b1;
    next_cycle();
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ss_n !== 1'b1) begin n_errors++; $display("FAIL reset_ss_n: got %b expected 1", ss_n); end
    n_checks++; if (mosi !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0 || rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got done=%b rx_valid=%b expected 0 0", done, rx_valid); end
    n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_checks++; if (fsm_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    start = 1'b0;
    rst   = 1'b0;
    next_cycle();
    n_checks++; if (busy !== 1'b0 || ss_n !== 1'b1) begin n_errors++; $display("FAIL post_reset_idle: got busy=%b ss_n=%b expected 0 1", busy, ss_n); end
  endtask

  task automatic test_write();
    logic [10:0] got = '0;
    int ss_low = 0, done_at = -1, done_cnt = 0, rx_cnt = 0, idle_mosi = 0;
    start_frame(2'b00, 8'hA5, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) next_cycle();
      if (!ss_n) ss_low++;
      if (ss_n && mosi) idle_mosi++;
      if (k >= 1 && k <= 11) got[11 - k] = mosi;
      if (done) begin done_cnt++; done_at = k; end
      if (rx_valid) rx_cnt++;
    end
    n_checks++; if (got !== 11'b000_1010_0101) begin n_errors++; $display("FAIL write_mosi: got %b expected 00010100101", got); end
    n_checks++; if (ss_low !== 12) begin n_errors++; $display("FAIL write_ss_low: got %0d expected 12", ss_low); end
    n_checks++; if (done_at !== 12 || done_cnt !== 1) begin n_errors++; $display("FAIL write_done: got at=%0d count=%0d expected at=12 count=1", done_at, done_cnt); end
    n_checks++; if (rx_cnt !== 0) begin n_errors++; $display("FAIL write_rx_valid: got %0d pulses expected 0", rx_cnt); end
    n_checks++; if (idle_mosi !== 0) begin n_errors++; $display("FAIL write_idle_mosi: got %0d high samples expected 0", idle_mosi); end
  endtask

  task automatic test_read();
    logic [7:0]  slave_byte = 8'h5A;
    logic [10:0] got = '0;
    int ss_low = 0, done_at = -1, rx_at = -1, wait_mosi = 0, idx;
    logic [7:0]  dout_at_rx = 8'h00;
    miso = 1'b1;
    start_frame(2'b11, 8'h00, 1'b0);
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) next_cycle();
      if (!ss_n) ss_low++;
      if (k >= 1 && k <= 11) got[11 - k] = mosi;
      if (k >= 12 && k <= 22 && mosi) wait_mosi++;
      if (done && done_at < 0) done_at = k;
      if (rx_valid && rx_at < 0) begin rx_at = k; dout_at_rx = dout; end
      // Slave drives the bit the master samples on edge E+k+1 (samples at E+15..E+22).
      idx = k + 1 - 15;
      miso = (idx >= 0 && idx <= 7) ? slave_byte[7 - idx] : 1'b1;
    end
    n_checks++; if (got !== 11'b111_0000_0000) begin n_errors++; $display("FAIL read_mosi: got %b expected 11100000000", got); end
    n_checks++; if (wait_mosi !== 0) begin n_errors++; $display("FAIL read_rx_mosi: got %0d high samples expected 0", wait_mosi); end
    n_checks++; if (ss_low !== 23) begin n_errors++; $display("FAIL read_ss_low: got %0d expected 23", ss_low); end
    n_checks++; if (done_at !== 23) begin n_errors++; $display("FAIL read_done_at: got %0d expected 23", done_at); end
    n_checks++; if (rx_at !== 23) begin n_errors++; $display("FAIL read_rx_valid_at: got %0d expected 23", rx_at); end
    n_checks++; if (dout_at_rx !== 8'h5A) begin n_errors++; $display("FAIL read_dout: got %h expected 5a", dout_at_rx); end
    n_checks++; if (dout !== 8'h5A) begin n_errors++; $display("FAIL read_dout_hold: got %h expected 5a", dout); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got1 = '0, got2 = '0;
    int acc2 = -1, gap_high = 0, done_cnt = 0, rx_cnt = 0;
    logic prev_busy = 1'b1;
    start_frame(2'b01, 8'h3C, 1'b1);
    cmd = 2'b10;
    din = 8'hA5;
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) next_cycle();
      if (k >= 1 && acc2 < 0 && busy && !prev_busy) begin acc2 = k; start = 1'b0; end
      if (k >= 1 && acc2 < 0 && ss_n) gap_high++;
      if (k >= 1 && k <= 11) got1[11 - k] = mosi;
      if (acc2 > 0 && k > acc2 && k <= acc2 + 11) got2[10 - (k - acc2 - 1)] = mosi;
      if (done) done_cnt++;
      if (rx_valid) rx_cnt++;
      prev_busy = busy;
    end
    start = 1'b0;
    n_checks++; if (got1 !== 11'b001_0011_1100) begin n_errors++; $display("FAIL b2b_mosi1: got %b expected 00100111100", got1); end
    n_checks++; if (acc2 !== 13) begin n_errors++; $display("FAIL b2b_accept2: got k=%0d expected 13", acc2); end
    n_checks++; if (gap_high !== 1) begin n_errors++; $display("FAIL b2b_ss_gap: got %0d high cycles expected 1", gap_high); end
    n_checks++; if (got2 !== 11'b110_1010_0101) begin n_errors++; $display("FAIL b2b_mosi2: got %b expected 11010100101", got2); end
    n_checks++; if (done_cnt !== 2 || rx_cnt !== 0) begin n_errors++; $display("FAIL b2b_pulses: got done=%0d rx=%0d expected 2 0", done_cnt, rx_cnt); end
    n_checks++; if (dout !== 8'h5A) begin n_errors++; $display("FAIL b2b_dout_kept: got %h expected 5a", dout); end
  endtask

  task automatic test_start_held();
    logic [10:0] got = '0;
    int busy_low = 0, done_cnt = 0;
    start_frame(2'b00, 8'hFF, 1'b1);
    // Changing the inputs mid-frame must not alter the frame in flight.
    cmd = 2'b01;
    din = 8'h00;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) next_cycle();
      if (k <= 11 && !busy) busy_low++;
      if (k >= 1 && k <= 11) got[11 - k] = mosi;
      if (done) done_cnt++;
      if (k == 12) start = 1'b0;
    end
    n_checks++; if (busy_low !== 0) begin n_errors++; $display("FAIL held_busy: got %0d low samples expected 0", busy_low); end
    n_checks++; if (got !== 11'b000_1111_1111) begin n_errors++; $display("FAIL held_mosi: got %b expected 00011111111", got); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL held_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy !== 1'b0 || ss_n !== 1'b1) begin n_errors++; $display("FAIL held_idle: got busy=%b ss_n=%b expected 0 1", busy, ss_n); end
  endtask

`ifdef SPI_MASTER_ABORT_EN
  task automatic test_abort();
    int late_done = 0;
    abort = 1'b1;
    next_cycle();
    next_cycle();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || ss_n !== 1'b1) begin n_errors++; $display("FAIL abort_idle: got busy=%b done=%b ss_n=%b expected 0 0 1", busy, done, ss_n); end
    abort = 1'b0;
    next_cycle();
    start_frame(2'b00, 8'hA5, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) next_cycle();
      if (k == 5) begin
        abort = 1'b0;
        n_checks++; if (ss_n !== 1'b1 || mosi !== 1'b0) begin n_errors++; $display("FAIL abort_ss_mosi: got ss_n=%b mosi=%b expected 1 0", ss_n, mosi); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_done_busy: got done=%b busy=%b expected 1 0", done, busy); end
        n_checks++; if (rx_valid !== 1'b0 || dout !== 8'h5A) begin n_errors++; $display("FAIL abort_dout: got rx_valid=%b dout=%h expected 0 5a", rx_valid, dout); end
      end
      if (k > 5 && done) late_done++;
      if (k == 4) abort = 1'b1;
    end
    n_checks++; if (late_done !== 0) begin n_errors++; $display("FAIL abort_late_done: got %0d expected 0", late_done); end
  endtask
`endif

  task automatic test_reset_midframe();
    int pulses = 0;
    miso = 1'b1;
    start_frame(2'b11, 8'h00, 1'b0);
    for (int k = 1; k <= 5; k++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    n_checks++; if (ss_n !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_ss_busy: got ss_n=%b busy=%b expected 1 0", ss_n, busy); end
    n_checks++; if (mosi !== 1'b0 || fsm_state !== 2'd0) begin n_errors++; $display("FAIL midrst_mosi_state: got mosi=%b state=%0d expected 0 0", mosi, fsm_state); end
    n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL midrst_dout: got %h expected 00", dout); end
    for (int k = 0; k < 30; k++) begin
      if (done || rx_valid || !ss_n) pulses++;
      next_cycle();
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d activity samples expected 0", pulses); end
  endtask

  // Test sequence and final report
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cmd   = 2'b00;
    din   = 8'h00;
    miso  = 1'b1;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_start_held();
`ifdef SPI_MASTER_ABORT_EN
    test_abort();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
